// File: rtl/cond_mac_chain.sv
// cond_mac_chain
//   Iterative conditional multiply-accumulate chain. It computes
//   x_0 = a_0*b_0 and, for i >= 1, x_i = x_{i-1} +/- a_i*b_i using one shared
//   multiplier and one accumulator, sequenced by an IDLE/MUL/ACC/DONE FSM.
//   The sign of each term is chosen by a_i >= b_i (MODE=0), or it is always
//   an add (MODE=1). All arithmetic is unsigned, modulo 2^WIDTH.
//
//   Optional feature: define COND_MAC_SAT_EN to make each accumulate step
//   saturate (add clamps to all-ones, subtract clamps to zero) and to flag
//   the event on sat. Without the macro, results wrap and sat is tied low.
//
// Parameters
//   WIDTH   data width of a_i, b_i and x_out
//   N_ELEM  number of (a_i, b_i) pairs, >= 1
//   MODE    0: conditional add/sub, 1: always add
//
// Ports
//   clk     rising-edge clock
//   reset   synchronous, active-high; aborts a run in progress
//   start   run request, sampled only in IDLE or DONE
//   a_flat  a_i = a_flat[i*WIDTH +: WIDTH]
//   b_flat  b_i = b_flat[i*WIDTH +: WIDTH]
//   x_out   registered result x_{N_ELEM-1}, held until the next completion
//   valid   one-cycle pulse when x_out has just been updated
//   busy    high while a run is in progress (MUL/ACC)
//   sat     saturation occurred during the last run
module cond_mac_chain #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned N_ELEM = 5,
    parameter int unsigned MODE   = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [N_ELEM*WIDTH-1:0]   a_flat,
    input  logic [N_ELEM*WIDTH-1:0]   b_flat,
    output logic [WIDTH-1:0]          x_out,
    output logic                      valid,
    output logic                      busy,
    output logic                      sat
);

    localparam int unsigned IDX_W = $clog2(N_ELEM + 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ACC,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [WIDTH-1:0]  a_mem [N_ELEM];
    logic [WIDTH-1:0]  b_mem [N_ELEM];
    logic [IDX_W-1:0]  idx;
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  prod;
    logic              ge;

    logic [WIDTH-1:0]  cur_a;
    logic [WIDTH-1:0]  cur_b;
    logic [WIDTH-1:0]  mul_lo;
    logic [WIDTH-1:0]  acc_nxt;
    logic              do_add;
    logic              is_last;
    logic              capture;

    assign capture = ((state == IDLE) || (state == DONE)) && start;
    assign is_last = (idx == IDX_W'(N_ELEM - 1));
    assign do_add  = (idx == '0) || (MODE == 1) || ge;
    assign mul_lo  = cur_a * cur_b;

    // Operand select written as a compare-mux so the index width never has
    // to match the array depth exactly for any N_ELEM.
    always_comb begin
        cur_a = '0;
        cur_b = '0;
        for (int unsigned i = 0; i < N_ELEM; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_a = a_mem[i];
                cur_b = b_mem[i];
            end
        end
    end

`ifdef COND_MAC_SAT_EN
    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] dif_ext;
    logic           ovf;
    logic           sat_r;

    // The extra top bit is the carry on add and the borrow on subtract.
    always_comb begin
        sum_ext = {1'b0, acc} + {1'b0, prod};
        dif_ext = {1'b0, acc} - {1'b0, prod};
        if (do_add) begin
            ovf     = sum_ext[WIDTH];
            acc_nxt = ovf ? '1 : sum_ext[WIDTH-1:0];
        end else begin
            ovf     = dif_ext[WIDTH];
            acc_nxt = ovf ? '0 : dif_ext[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_r <= 1'b0;
        end else if (capture) begin
            sat_r <= 1'b0;
        end else if ((state == ACC) && ovf) begin
            sat_r <= 1'b1;
        end
    end

    assign sat = sat_r;
`else
    always_comb begin
        acc_nxt = do_add ? (acc + prod) : (acc - prod);
    end

    assign sat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        valid     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = MUL;
            end
            MUL: begin
                busy      = 1'b1;
                state_nxt = ACC;
            end
            ACC: begin
                busy      = 1'b1;
                state_nxt = is_last ? DONE : MUL;
            end
            DONE: begin
                valid     = 1'b1;
                state_nxt = start ? MUL : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx   <= '0;
            acc   <= '0;
            prod  <= '0;
            ge    <= 1'b0;
            x_out <= '0;
        end else if (capture) begin
            for (int unsigned i = 0; i < N_ELEM; i++) begin
                a_mem[i] <= a_flat[i*WIDTH +: WIDTH];
                b_mem[i] <= b_flat[i*WIDTH +: WIDTH];
            end
            idx <= '0;
            acc <= '0;
        end else begin
            case (state)
                MUL: begin
                    prod <= mul_lo;
                    ge   <= (cur_a >= cur_b);
                end
                ACC: begin
                    acc <= acc_nxt;
                    if (is_last) begin
                        x_out <= acc_nxt;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cond_mac_chain.sv
// tb_cond_mac_chain
//   Scoreboard bench for cond_mac_chain. Three instances share clock and
//   reset: (N=5, MODE=0), (N=3, MODE=1) and (N=1, MODE=0). The driver pushes
//   the expected result, sat flag and completion cycle for each run; the
//   monitor pops on every valid pulse and also watches busy/valid exclusion,
//   x_out holding between completions and the post-reset state.
module tb_cond_mac_chain;

    typedef logic [31:0] vec_t [5];

    typedef struct {
        int          d;
        logic [31:0] x;
        logic        s;
        int          cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start_v [3];
    vec_t         av [3];
    vec_t         bv [3];
    logic [159:0] a0, b0;
    logic [95:0]  a1, b1;
    logic [31:0]  a2, b2;
    logic [31:0]  xo [3];
    logic         vld [3];
    logic         bsy [3];
    logic         st [3];

    exp_t         sb [$];
    logic [31:0]  last_x [3];
    bit           rst_pend = 1'b1;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign a0 = {av[0][4], av[0][3], av[0][2], av[0][1], av[0][0]};
    assign b0 = {bv[0][4], bv[0][3], bv[0][2], bv[0][1], bv[0][0]};
    assign a1 = {av[1][2], av[1][1], av[1][0]};
    assign b1 = {bv[1][2], bv[1][1], bv[1][0]};
    assign a2 = av[2][0];
    assign b2 = bv[2][0];

    cond_mac_chain #(.WIDTH(32), .N_ELEM(5), .MODE(0)) u_n5 (
        .clk(clk), .reset(reset), .start(start_v[0]), .a_flat(a0), .b_flat(b0),
        .x_out(xo[0]), .valid(vld[0]), .busy(bsy[0]), .sat(st[0]));

    cond_mac_chain #(.WIDTH(32), .N_ELEM(3), .MODE(1)) u_n3 (
        .clk(clk), .reset(reset), .start(start_v[1]), .a_flat(a1), .b_flat(b1),
        .x_out(xo[1]), .valid(vld[1]), .busy(bsy[1]), .sat(st[1]));

    cond_mac_chain #(.WIDTH(32), .N_ELEM(1), .MODE(0)) u_n1 (
        .clk(clk), .reset(reset), .start(start_v[2]), .a_flat(a2), .b_flat(b2),
        .x_out(xo[2]), .valid(vld[2]), .busy(bsy[2]), .sat(st[2]));

    function automatic int n_of(input int d);
        return (d == 0) ? 5 : (d == 1) ? 3 : 1;
    endfunction

    function automatic int mode_of(input int d);
        return (d == 1) ? 1 : 0;
    endfunction

    // Reference: the chain evaluated directly with wide signed arithmetic.
    function automatic void model(input int n, input int mode, input vec_t a, input vec_t b,
                                  output logic [31:0] x, output logic s);
        longint      acc;
        longint      p;
        logic [63:0] full;
        logic [63:0] accv;
        acc = 0;
        s   = 1'b0;
        for (int i = 0; i < n; i++) begin
            full = {32'd0, a[i]} * {32'd0, b[i]};
            p    = longint'({32'd0, full[31:0]});
            if (i == 0 || mode == 1 || a[i] >= b[i]) acc = acc + p;
            else                                     acc = acc - p;
`ifdef COND_MAC_SAT_EN
            if (acc > 64'sd4294967295) begin acc = 64'sd4294967295; s = 1'b1; end
            if (acc < 0)               begin acc = 0;               s = 1'b1; end
`else
            acc = acc & 64'sh0000_0000_FFFF_FFFF;
`endif
        end
        accv = 64'(acc);
        x    = accv[31:0];
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        for (int i = 0; i < 5; i++) begin
            if ($urandom_range(0, 1) == 1) v[i] = 32'($urandom_range(0, 15));
            else                           v[i] = $urandom;
        end
        return v;
    endfunction

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%h expected=%h at cycle %0d", name, d, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int d, input vec_t a, input vec_t b);
        exp_t e;
        e.d   = d;
        e.cyc = cyc + 1 + 2 * n_of(d);
        model(n_of(d), mode_of(d), a, b, e.x, e.s);
        sb.push_back(e);
    endtask

    task automatic wait_valid(input int d);
        for (int t = 0; t < 200; t++) begin
            @(posedge clk); #1;
            if (vld[d]) return;
        end
        chk("valid_timeout", d, 64'd0, 64'd1);
    endtask

    task automatic run(input int d, input vec_t a, input vec_t b, input bit disturb);
        @(posedge clk); #1;
        av[d]      = a;
        bv[d]      = b;
        start_v[d] = 1'b1;
        push_exp(d, a, b);
        @(posedge clk); #1;
        start_v[d] = 1'b0;
        if (disturb) begin
            for (int k = 1; k <= 2 * n_of(d) - 2; k++) begin
                @(posedge clk); #1;
                start_v[d] = 1'($urandom_range(0, 1));
                av[d][$urandom_range(0, 4)] = $urandom;
            end
            @(posedge clk); #1;
            start_v[d] = 1'b0;
        end
        wait_valid(d);
    endtask

    // start stays high across the whole first run and into DONE.
    task automatic back_to_back(input vec_t a1v, input vec_t b1v, input vec_t a2v, input vec_t b2v);
        @(posedge clk); #1;
        av[0]      = a1v;
        bv[0]      = b1v;
        start_v[0] = 1'b1;
        push_exp(0, a1v, b1v);
        wait_valid(0);
        av[0] = a2v;
        bv[0] = b2v;
        push_exp(0, a2v, b2v);
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        wait_valid(0);
    endtask

    task automatic reset_mid_run(input vec_t a, input vec_t b);
        int nb;
        @(posedge clk); #1;
        av[0]      = a;
        bv[0]      = b;
        start_v[0] = 1'b1;
        push_exp(0, a, b);
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        nb = 1;
        for (int t = 0; t < 50 && nb < 4; t++) begin
            @(posedge clk); #1;
            if (bsy[0]) nb++;
        end
        chk("busy_cycles_before_reset", 0, 64'(nb), 64'd4);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            rst_pend = 1'b1;
            sb.delete();
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (rst_pend) begin
                    chk("reset_busy", d, 64'(bsy[d]), 64'd0);
                    chk("reset_valid", d, 64'(vld[d]), 64'd0);
                    chk("reset_x_out", d, 64'(xo[d]), 64'd0);
                    chk("reset_sat", d, 64'(st[d]), 64'd0);
                    last_x[d] = 32'd0;
                end else begin
                    chk("busy_valid_excl", d, 64'(bsy[d] & vld[d]), 64'd0);
                    if (vld[d]) begin
                        if (sb.size() == 0 || sb[0].d != d) begin
                            chk("unexpected_valid", d, 64'd1, 64'd0);
                        end else begin
                            e = sb.pop_front();
                            chk("x_out", d, 64'(xo[d]), 64'(e.x));
                            chk("sat", d, 64'(st[d]), 64'(e.s));
                            chk("latency_cycle", d, 64'(cyc), 64'(e.cyc));
                            last_x[d] = e.x;
                        end
                    end else begin
                        chk("x_out_hold", d, 64'(xo[d]), 64'(last_x[d]));
                    end
                end
            end
            rst_pend = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t ta, tb_v, tc, td;
        for (int d = 0; d < 3; d++) begin
            start_v[d] = 1'b0;
            last_x[d]  = 32'd0;
            for (int i = 0; i < 5; i++) begin
                av[d][i] = 32'd0;
                bv[d][i] = 32'd0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        ta   = '{1, 2, 3, 4, 5};
        tb_v = '{2, 2, 2, 2, 2};
        run(0, ta, tb_v, 1'b0);

        tc = '{1, 1, 0, 0, 0};
        td = '{1, 3, 0, 0, 0};
        run(0, tc, td, 1'b0);

        run(0, '{32'h8000_0000, 32'h8000_0000, 0, 0, 0}, '{1, 1, 0, 0, 0}, 1'b0);

        run(0, ta, tb_v, 1'b1);

        back_to_back(ta, tb_v, tc, td);

        reset_mid_run(ta, tb_v);
        run(0, ta, tb_v, 1'b0);

        run(1, '{4, 1, 5, 0, 0}, '{3, 2, 1, 0, 0}, 1'b0);
        run(2, '{7, 0, 0, 0, 0}, '{6, 0, 0, 0, 0}, 1'b0);

        for (int r = 0; r < 30; r++) begin
            run(0, rnd_vec(), rnd_vec(), 1'($urandom_range(0, 1)));
        end
        for (int r = 0; r < 10; r++) begin
            run(1, rnd_vec(), rnd_vec(), 1'b0);
            run(2, rnd_vec(), rnd_vec(), 1'b0);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", 0, 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
